dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller FSM.
- Sits between the processor's memory stage and the external cache array plus the four-bank main memory.
- Produces the memory-stage handshake (Done/Stall) and the DCacheReq/DCacheHit events counted by the processor perf bench.
- Line = 4 words (8 bytes). Address split: tag[15:11], index[10:3], offset[2:0]. offset[0] must be 0.

Parameters:
- MEM_LAT, 2, cycles from a memory read issue to its read data being valid on mem_data_out.
- LINE_WORDS, 4, words per cache line; fixed, must be 4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- Addr  in  16  byte address from the memory stage
- DataIn  in  16  store data
- Rd  in  1  load request
- Wr  in  1  store request
- DataOut  out  16  load data, valid when Done=1
- Done  out  1  request completes this cycle
- Stall  out  1  memory stage must hold its request
- CacheHit  out  1  request completed as a first-access hit (qualified by Done)
- DCacheReq  out  1  pulses once per accepted request, in its first cycle
- Err  out  1  illegal request (Rd&Wr, or Addr[0]=1)
- c_en, c_comp, c_write, c_valid_in  out  1 each  cache array controls
- c_tag  out  5  cache tag
- c_index  out  8  cache index
- c_offset  out  3  cache offset
- c_data_in  out  16  cache write data
- c_hit, c_dirty, c_valid  in  1 each  cache array status
- c_tag_out  in  5  victim tag
- c_data_out  in  16  cache read data
- mem_addr  out  16  main-memory address
- mem_data_in  out  16  main-memory write data
- mem_rd, mem_wr  out  1 each  main-memory read/write strobes
- mem_data_out  in  16  main-memory read data
- mem_stall  in  1  main memory cannot accept a request this cycle

Behaviour:
- Reset: state=IDLE; all counters and the fill tracker cleared. All outputs 0 (DataOut=0, mem_rd=mem_wr=0, c_en=0).
- Reset asserted mid-miss aborts the transaction: no memory strobe or cache write is issued in the reset cycle, and the line is left as last written.
- States: IDLE, WB, ALLOC, FINAL.

IDLE:
- With Rd^Wr and Addr[0]=0: drive c_en=1, c_comp=1, c_write=Wr, fields from Addr, c_data_in=DataIn. Assert DCacheReq=1.
- Hit (c_hit & c_valid): Done=1, CacheHit=1, DataOut=c_data_out, Stall=0 in the same cycle; stay in IDLE.
- Miss: latch Addr, DataIn, Rd and Wr; assert Stall=1.
  - If c_valid & c_dirty: latch c_tag_out and go to WB.
  - Otherwise go to ALLOC.
- Err: asserted combinationally when Rd&Wr, or (Rd|Wr)&Addr[0]. Done=1 the same cycle; no cache or memory access; stay in IDLE.

WB:
- Word counter w=0..3.
- Each cycle: c_en=1, c_comp=0, c_write=0, c_offset={w,0}.
- mem_wr=1, mem_addr={victim_tag,index,w,1'b0}, mem_data_in=c_data_out.
- If mem_stall, w holds and the write is reissued next cycle.
- After w=3 is accepted, go to ALLOC.

ALLOC:
- Issue counter i=0..3: mem_rd=1, mem_addr={tag,index,i,1'b0}. i advances only when mem_stall=0.
- Each accepted issue enters the fill tracker tagged with word i.
- When a tracked read matures (MEM_LAT cycles after issue): c_en=1, c_comp=0, c_write=1, c_offset={k,0}, c_data_in=mem_data_out, c_tag=latched tag, c_valid_in=1.
- Leave for FINAL when all 4 words have been filled.
- Issue and fill may overlap in the same cycle. The cache port serves the fill; issue does not use the cache port.

FINAL:
- Replay the latched request: c_comp=1, c_write=latched Wr.
- Done=1, CacheHit=0, Stall=0, DataOut=c_data_out. Return to IDLE.

General rules:
- Stall=1 in WB and ALLOC, and in the IDLE miss cycle.
- New Rd/Wr is ignored while not in IDLE.
- Latency with no mem_stall: hit = 0 extra cycles.
  - Clean miss: Done at N+1+(4+MEM_LAT) = N+7.
  - Dirty miss: Done at N+11.
- A store miss leaves the line dirty, written via the FINAL compare write.

Decomposition:
- dcache_pkg:
  - State enum (IDLE/WB/ALLOC/FINAL).
  - Constants: LINE_WORDS=4, TAG_W=5, IDX_W=8, OFF_W=3.
  - Address-field slice functions.
- Sub-module dcache_fill_tracker: MEM_LAT-deep shift register of {valid, word[1:0]}. Output fill_valid/fill_word; clear on rst.

Test Plan:
- Read to 0x0010 after reset (cold) -> DCacheReq pulse; mem_rd to 0x0010, 0x0012, 0x0014, 0x0016; Done 7 cycles later with CacheHit=0 and DataOut = memory[0x0010].
- Repeat read to 0x0012 -> Done same cycle, CacheHit=1, no mem_rd.
- Write 0xBEEF to 0x0010, then read 0x0810 (same index, new tag) -> four mem_wr to 0x0010..0x0016, with 0xBEEF at 0x0010; then four mem_rd; Done at +11.
- mem_stall held high 3 cycles during ALLOC issue i=1 -> mem_addr holds at 0x0012; Done delayed exactly 3 cycles; fill words stay correct.
- Rd=1 with Addr=0x0011, and separately Rd=Wr=1 -> Err=1, Done=1 same cycle; no mem or cache write; state stays IDLE.
- rst asserted in 2nd ALLOC cycle -> next cycle all outputs 0, state IDLE; a subsequent hit/miss sequence behaves as from cold.

Source files
------------

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and constants for the direct-mapped write-back data cache
// controller: FSM state encoding, line/field geometry and the address split.
// -----------------------------------------------------------------------------
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_ALLOC = 2'd2,
    ST_FINAL = 2'd3
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 5;
  localparam int IDX_W      = 8;
  localparam int OFF_W      = 3;

  // Byte address as seen by the cache: tag | index | byte offset in line.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } addr_t;

  function automatic addr_t split_addr(input logic [15:0] a);
    return addr_t'(a);
  endfunction

endpackage

// File: rtl/dcache_fill_tracker.sv
// -----------------------------------------------------------------------------
// dcache_fill_tracker
// Follows outstanding line-fill reads through main memory. Every accepted read
// issue enters a MEM_LAT-deep shift register together with its word number;
// it drops out of the far end in the cycle its data is on mem_data_out.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset (clears all stages)
//   issue_valid   a read issue was accepted by memory this cycle
//   issue_word    word number (0..3) of that read
//   fill_valid    read data for fill_word is valid this cycle
//   fill_word     word number of the maturing read
// -----------------------------------------------------------------------------
module dcache_fill_tracker #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [1:0] issue_word,
  output logic       fill_valid,
  output logic [1:0] fill_word
);

  logic       r_valid [MEM_LAT];
  logic [1:0] r_word  [MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        r_valid[i] <= 1'b0;
        r_word[i]  <= 2'd0;
      end
    end else begin
      r_valid[0] <= issue_valid;
      r_word[0]  <= issue_word;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_word[i]  <= r_word[i-1];
      end
    end
  end

  assign fill_valid = r_valid[MEM_LAT-1];
  assign fill_word  = r_word[MEM_LAT-1];

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller. Looks up
// the external cache array in IDLE, writes a dirty victim back (WB), refills
// the line from main memory with overlapped issue/fill (ALLOC) and replays the
// original request against the refilled line (FINAL).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   Addr, DataIn, Rd, Wr         memory-stage request
//   DataOut, Done, Stall         memory-stage handshake
//   CacheHit, DCacheReq, Err     hit / request events, illegal-request flag
//   c_*  (out)                   cache array control, fields and write data
//   c_hit, c_dirty, c_valid,
//   c_tag_out, c_data_out (in)   cache array status and read data
//   mem_addr, mem_data_in,
//   mem_rd, mem_wr (out)         main-memory request
//   mem_data_out, mem_stall (in) main-memory read data and back-pressure
// -----------------------------------------------------------------------------
module dcache_ctrl #(
  parameter int MEM_LAT    = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        DCacheReq,
  output logic        Err,
  output logic        c_en,
  output logic        c_comp,
  output logic        c_write,
  output logic        c_valid_in,
  output logic [4:0]  c_tag,
  output logic [7:0]  c_index,
  output logic [2:0]  c_offset,
  output logic [15:0] c_data_in,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic [4:0]  c_tag_out,
  input  logic [15:0] c_data_out,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall
);

  import dcache_pkg::*;

  state_t      r_state, w_next_state;
  logic [15:0] r_addr, r_data;
  logic        r_wr;
  logic [4:0]  r_victim_tag;
  logic [1:0]  r_wb_cnt;
  logic [2:0]  r_issue_cnt;   // one bit wider than a word number: 4 means all issued
  logic [1:0]  r_fill_cnt;

  addr_t       w_req_f, w_lat_f;
  logic        w_err_req, w_req_ok, w_cache_hit;
  logic        w_issue, w_issue_acc, w_fill;
  logic        w_fill_valid;
  logic [1:0]  w_fill_word;

  assign w_req_f     = split_addr(Addr);
  assign w_lat_f     = split_addr(r_addr);
  assign w_err_req   = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign w_req_ok    = (Rd ^ Wr) & ~Addr[0];
  assign w_cache_hit = c_hit & c_valid;

  // Reset gating keeps a mid-miss reset from leaking a strobe into memory.
  assign w_issue     = !rst && (r_state == ST_ALLOC) && (r_issue_cnt < 3'(LINE_WORDS));
  assign w_issue_acc = w_issue & ~mem_stall;
  assign w_fill      = !rst && (r_state == ST_ALLOC) && w_fill_valid;

  dcache_fill_tracker #(.MEM_LAT(MEM_LAT)) u_fill_tracker (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(w_issue_acc),
    .issue_word (r_issue_cnt[1:0]),
    .fill_valid (w_fill_valid),
    .fill_word  (w_fill_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= 16'd0;
      r_data       <= 16'd0;
      r_wr         <= 1'b0;
      r_victim_tag <= 5'd0;
      r_wb_cnt     <= 2'd0;
      r_issue_cnt  <= 3'd0;
      r_fill_cnt   <= 2'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_req_ok && !w_cache_hit) begin
            r_addr       <= Addr;
            r_data       <= DataIn;
            r_wr         <= Wr;     // Rd is implied by !r_wr for a legal request
            r_victim_tag <= c_tag_out;
            r_wb_cnt     <= 2'd0;
            r_issue_cnt  <= 3'd0;
            r_fill_cnt   <= 2'd0;
          end
        end
        ST_WB: begin
          if (!mem_stall) r_wb_cnt <= r_wb_cnt + 2'd1;
        end
        ST_ALLOC: begin
          if (w_issue_acc) r_issue_cnt <= r_issue_cnt + 3'd1;
          if (w_fill)      r_fill_cnt  <= r_fill_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    DataOut      = 16'd0;
    Done         = 1'b0;
    Stall        = 1'b0;
    CacheHit     = 1'b0;
    DCacheReq    = 1'b0;
    Err          = 1'b0;
    c_en         = 1'b0;
    c_comp       = 1'b0;
    c_write      = 1'b0;
    c_valid_in   = 1'b0;
    c_tag        = 5'd0;
    c_index      = 8'd0;
    c_offset     = 3'd0;
    c_data_in    = 16'd0;
    mem_addr     = 16'd0;
    mem_data_in  = 16'd0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;

    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          Err = w_err_req;
          if (w_err_req) begin
            Done = 1'b1;
          end else if (w_req_ok) begin
            c_en       = 1'b1;
            c_comp     = 1'b1;
            c_write    = Wr;
            c_valid_in = Wr;
            c_tag      = w_req_f.tag;
            c_index    = w_req_f.index;
            c_offset   = w_req_f.offset;
            c_data_in  = DataIn;
            DCacheReq  = 1'b1;
            if (w_cache_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = c_data_out;
            end else begin
              Stall        = 1'b1;
              w_next_state = (c_valid & c_dirty) ? ST_WB : ST_ALLOC;
            end
          end
        end

        ST_WB: begin
          // Cache read data flows straight through to the memory write port.
          Stall       = 1'b1;
          c_en        = 1'b1;
          c_tag       = r_victim_tag;
          c_index     = w_lat_f.index;
          c_offset    = {r_wb_cnt, 1'b0};
          mem_wr      = 1'b1;
          mem_addr    = {r_victim_tag, w_lat_f.index, r_wb_cnt, 1'b0};
          mem_data_in = c_data_out;
          if (!mem_stall && r_wb_cnt == 2'd3) w_next_state = ST_ALLOC;
        end

        ST_ALLOC: begin
          Stall = 1'b1;
          if (w_issue) begin
            mem_rd   = 1'b1;
            mem_addr = {w_lat_f.tag, w_lat_f.index, r_issue_cnt[1:0], 1'b0};
          end
          // The cache port belongs to the fill; issue only needs the memory port.
          if (w_fill) begin
            c_en       = 1'b1;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_tag      = w_lat_f.tag;
            c_index    = w_lat_f.index;
            c_offset   = {w_fill_word, 1'b0};
            c_data_in  = mem_data_out;
            if (r_fill_cnt == 2'd3) w_next_state = ST_FINAL;
          end
        end

        ST_FINAL: begin
          // Replaying the request as a compare access marks a store line dirty.
          c_en         = 1'b1;
          c_comp       = 1'b1;
          c_write      = r_wr;
          c_valid_in   = r_wr;
          c_tag        = w_lat_f.tag;
          c_index      = w_lat_f.index;
          c_offset     = w_lat_f.offset;
          c_data_in    = r_data;
          Done         = 1'b1;
          DataOut      = c_data_out;
          w_next_state = ST_IDLE;
        end

        default: w_next_state = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
// Self-checking bench for dcache_ctrl with a behavioural cache array and a
// MEM_LAT-latency main memory. Requests come from a vector table; expected
// results go into a scoreboard queue when a request is driven and are popped
// when the controller raises Done. Hand-written sequences cover reset.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn;
  logic        Rd, Wr;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, DCacheReq, Err;
  logic        c_en, c_comp, c_write, c_valid_in;
  logic [4:0]  c_tag;
  logic [7:0]  c_index;
  logic [2:0]  c_offset;
  logic [15:0] c_data_in;
  logic        c_hit, c_dirty, c_valid;
  logic [4:0]  c_tag_out;
  logic [15:0] c_data_out;
  logic [15:0] mem_addr, mem_data_in;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_data_out;
  logic        mem_stall;

  always #5 clk = ~clk;

  dcache_ctrl #(.MEM_LAT(MEM_LAT), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
    .DCacheReq(DCacheReq), .Err(Err),
    .c_en(c_en), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_tag(c_tag), .c_index(c_index), .c_offset(c_offset), .c_data_in(c_data_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall)
  );

  // ---------------- behavioural cache array and main memory ----------------
  logic [4:0]  m_tag   [256];
  logic        m_valid [256];
  logic        m_dirty [256];
  logic [15:0] m_data  [1024];
  logic [15:0] mem     [32768];
  logic [15:0] ref_mem [32768];   // architectural memory image for expected loads
  logic        model_clr;
  logic [MEM_LAT-1:0] rp_v;
  logic [15:0] rp_a [MEM_LAT];
  logic [9:0]  w_didx;

  function automatic logic [15:0] mem_init(input int unsigned w);
    logic [15:0] x;
    x = 16'(w);
    return (x ^ 16'hA5C3) + {x[7:0], x[15:8]};
  endfunction

  assign w_didx       = {c_index, c_offset[2:1]};
  assign c_valid      = c_en & m_valid[c_index];
  assign c_dirty      = c_en & m_dirty[c_index];
  assign c_hit        = c_en & c_comp & m_valid[c_index] & (m_tag[c_index] == c_tag);
  assign c_tag_out    = m_tag[c_index];
  assign c_data_out   = m_data[w_didx];
  assign mem_data_out = rp_v[MEM_LAT-1] ? mem[rp_a[MEM_LAT-1][15:1]] : 16'h0000;

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 256; i++) begin
        m_tag[i] <= 5'd0; m_valid[i] <= 1'b0; m_dirty[i] <= 1'b0;
      end
      for (int i = 0; i < 1024; i++) m_data[i] <= 16'h0000;
      for (int i = 0; i < 32768; i++) mem[i] <= mem_init(i);
      rp_v <= '0;
      for (int i = 0; i < MEM_LAT; i++) rp_a[i] <= 16'h0000;
    end else begin
      if (c_en && c_write) begin
        if (c_comp) begin
          if (m_valid[c_index] && m_tag[c_index] == c_tag) begin
            m_data[w_didx]  <= c_data_in;
            m_dirty[c_index] <= 1'b1;
          end
        end else begin
          m_data[w_didx]   <= c_data_in;
          m_tag[c_index]   <= c_tag;
          m_valid[c_index] <= c_valid_in;
          m_dirty[c_index] <= 1'b0;
        end
      end
      if (mem_wr && !mem_stall) mem[mem_addr[15:1]] <= mem_data_in;
      rp_v    <= {rp_v[MEM_LAT-2:0], mem_rd & ~mem_stall};
      rp_a[0] <= mem_addr;
      for (int i = 1; i < MEM_LAT; i++) rp_a[i] <= rp_a[i-1];
    end
  end

  // ---------------- checking infrastructure ----------------
  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, data;
    logic        err, hit;
    int          lat;
    logic        dirty;
    logic [15:0] victim;
    int          st_start, st_len;
  } tv_t;

  typedef struct {
    logic [15:0] data;
    logic        hit, err, chk_data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic tv_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] data, input logic err, input logic hit,
                             input int lat, input logic dirty, input logic [15:0] victim,
                             input int st_start, input int st_len);
    tv_t t;
    t.rd = rd; t.wr = wr; t.addr = addr; t.data = data; t.err = err; t.hit = hit;
    t.lat = lat; t.dirty = dirty; t.victim = victim; t.st_start = st_start; t.st_len = st_len;
    return t;
  endfunction

  task automatic do_req(input tv_t v);
    exp_t        e, got;
    int          nreq, n, done_cyc;
    bit          done;
    logic [1:0]  nw;
    logic [15:0] rd_log[$];
    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];

    e.data     = ref_mem[v.addr[15:1]];
    e.hit      = v.hit;
    e.err      = v.err;
    e.lat      = v.lat;
    e.chk_data = v.rd & ~v.wr & ~v.err;
    sb.push_back(e);
    nreq = 0; done = 1'b0; done_cyc = -1;

    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      Rd = v.rd; Wr = v.wr; Addr = v.addr; DataIn = v.data;
      mem_stall = (v.st_len > 0) && (cyc >= v.st_start) && (cyc < v.st_start + v.st_len);
      #1;
      if (DCacheReq) nreq++;
      if (mem_rd && mem_stall) begin
        n = rd_log.size(); nw = n[1:0];
        check("stall_addr_hold", 32'(mem_addr), 32'({v.addr[15:3], nw, 1'b0}));
      end
      if (mem_rd && !mem_stall) rd_log.push_back(mem_addr);
      if (mem_wr && !mem_stall) begin
        wr_a.push_back(mem_addr);
        wr_d.push_back(mem_data_in);
      end
      if (Done) begin
        done = 1'b1;
        done_cyc = cyc;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard: Done with no expected entry, got none, expected one");
        end else begin
          got = sb.pop_front();
          check("err", 32'(Err), 32'(got.err));
          if (got.err) begin
            check("err_quiet", 32'({c_en, c_write, mem_rd, mem_wr, Stall, DCacheReq}), 32'd0);
          end else begin
            check("latency", 32'(cyc), 32'(got.lat));
            check("cache_hit", 32'(CacheHit), 32'(got.hit));
            if (got.chk_data) check("data_out", 32'(DataOut), 32'(got.data));
          end
        end
      end
    end
    mem_stall = 1'b0;

    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no Done for addr %h, expected Done within 64 cycles", v.addr);
      void'(sb.pop_front());
    end

    if (!v.err) begin
      check("req_pulse", 32'(nreq), 32'd1);
      check("n_mem_rd", 32'(rd_log.size()), v.hit ? 32'd0 : 32'd4);
      if (!v.hit)
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
          check("rd_addr", 32'(rd_log[i]), 32'({v.addr[15:3], 2'(i), 1'b0}));
      check("n_mem_wr", 32'(wr_a.size()), v.dirty ? 32'd4 : 32'd0);
      if (v.dirty)
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
          check("wb_addr", 32'(wr_a[i]), 32'({v.victim[15:3], 2'(i), 1'b0}));
          check("wb_data", 32'(wr_d[i]), 32'(ref_mem[{v.victim[15:3], 2'(i)}]));
        end
      if (v.wr) ref_mem[v.addr[15:1]] = v.data;
    end else begin
      check("err_no_req", 32'(nreq), 32'd0);
    end

    $display("txn %0d rd=%0b wr=%0b addr=%h data=%h done_cyc=%0d hit=%0b err=%0b dout=%h",
             n_txn, v.rd, v.wr, v.addr, v.data, done_cyc, CacheHit, Err, DataOut);
    n_txn++;
  endtask

  // ---------------- stimulus ----------------
  tv_t tv[13];

  initial begin
    rst = 1'b1; model_clr = 1'b1;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000; mem_stall = 1'b0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = mem_init(i);

    // Outputs stay quiet under reset even with a request presented.
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h0010; #1;
    check("rst_ctrl", 32'({Done, Stall, CacheHit, DCacheReq, Err, c_en, c_write, mem_rd, mem_wr}), 32'd0);
    check("rst_dout", 32'(DataOut), 32'd0);
    @(negedge clk); model_clr = 1'b0; Rd = 1'b0;
    @(negedge clk); rst = 1'b0;

    //            rd    wr    addr      data      err   hit   lat dirty victim   st  len
    tv[0]  = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0,  7, 1'b0, 16'h0000, 0, 0);
    tv[1]  = mk(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b1,  0, 1'b0, 16'h0000, 0, 0);
    tv[2]  = mk(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1,  0, 1'b0, 16'h0000, 0, 0);
    tv[3]  = mk(1'b1, 1'b0, 16'h0810, 16'h0000, 1'b0, 1'b0, 11, 1'b1, 16'h0010, 0, 0);
    tv[4]  = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0,  7, 1'b0, 16'h0000, 0, 0);
    tv[5]  = mk(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0,  0, 1'b0, 16'h0000, 0, 0);
    tv[6]  = mk(1'b1, 1'b1, 16'h0012, 16'h5555, 1'b1, 1'b0,  0, 1'b0, 16'h0000, 0, 0);
    tv[7]  = mk(1'b1, 1'b0, 16'h0014, 16'h0000, 1'b0, 1'b1,  0, 1'b0, 16'h0000, 0, 0);
    tv[8]  = mk(1'b0, 1'b1, 16'h2020, 16'h1234, 1'b0, 1'b0,  7, 1'b0, 16'h0000, 0, 0);
    tv[9]  = mk(1'b1, 1'b0, 16'h2020, 16'h0000, 1'b0, 1'b1,  0, 1'b0, 16'h0000, 0, 0);
    tv[10] = mk(1'b1, 1'b0, 16'h2822, 16'h0000, 1'b0, 1'b0, 11, 1'b1, 16'h2020, 0, 0);
    tv[11] = mk(1'b1, 1'b0, 16'h3030, 16'h0000, 1'b0, 1'b0, 10, 1'b0, 16'h0000, 2, 3);
    tv[12] = mk(1'b1, 1'b0, 16'h3036, 16'h0000, 1'b0, 1'b1,  0, 1'b0, 16'h0000, 0, 0);

    for (int i = 0; i < 13; i++) do_req(tv[i]);

    // Reset in the second ALLOC cycle of a cold miss aborts the fill.
    @(negedge clk); Rd = 1'b1; Wr = 1'b0; Addr = 16'h4040; #1;
    check("rs_miss", 32'({DCacheReq, Stall, Done}), 32'b110);
    @(negedge clk); #1;
    check("rs_alloc_issue", 32'({mem_rd, mem_addr}), 32'({1'b1, 16'h4040}));
    @(negedge clk); rst = 1'b1; #1;
    check("rs_gate", 32'({mem_rd, mem_wr, c_en, c_write, Stall, Done}), 32'd0);
    @(negedge clk); rst = 1'b0; Rd = 1'b0; #1;
    check("rs_after_ctrl", 32'({Done, Stall, CacheHit, DCacheReq, Err, c_en, c_write, mem_rd, mem_wr}), 32'd0);
    check("rs_after_dout", 32'(DataOut), 32'd0);

    do_req(mk(1'b1, 1'b0, 16'h4040, 16'h0000, 1'b0, 1'b0, 7, 1'b0, 16'h0000, 0, 0));
    do_req(mk(1'b1, 1'b0, 16'h4046, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 16'h0000, 0, 0));

    @(negedge clk); Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
